// File: rtl/load_unit_pkg.sv
// load_unit_pkg: shared constants, load state encoding and funct3 legality helper
package load_unit_pkg;
  localparam int MSB = 31;
  localparam int LSB = 0;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} ld_state_t;
  function automatic logic legal_f3(input logic [2:0] f);
    return f inside {LB, LH, LW, LBU, LHU};
  endfunction
endpackage

// File: rtl/load_unit_align.sv
// load_align: extracts and extends a byte/halfword/word from two adjacent memory words
module load_align
  import load_unit_pkg::*;
(
  input  logic [MSB:LSB] word0,
  input  logic [MSB:LSB] word1,
  input  logic [1:0]     offset,
  input  logic [2:0]     funct3,
  output logic [MSB:LSB] data
);
  logic [MSB:LSB] sh;
  always_comb begin
    sh   = 32'({word1, word0} >> {offset, 3'b000});
    data = funct3 == LB  ? {{24{sh[7]}}, sh[7:0]} :
           funct3 == LBU ? {24'b0, sh[7:0]} :
           funct3 == LH  ? {{16{sh[15]}}, sh[15:0]} :
           funct3 == LHU ? {16'b0, sh[15:0]} : sh;
  end
endmodule

// File: rtl/load_unit.sv
// load_unit: issues aligned memory reads for a load, splitting word-crossing accesses in two
module load_unit
  import load_unit_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           ld_valid,
  output logic           ld_ready,
  input  logic [MSB:LSB] idata,
  input  logic [MSB:LSB] daddr,
  output logic           mem_req,
  output logic [MSB:LSB] mem_addr,
  input  logic           mem_gnt,
  input  logic           mem_rvalid,
  input  logic [MSB:LSB] mem_rdata,
  output logic           rd_valid,
  output logic [MSB:LSB] rd_data,
  output logic           rd_err
);
  ld_state_t state, nxt;
  logic [2:0] f3;
  logic [MSB:LSB] addr, w0, w1, aligned, base;
  logic split, err, legal, split_in, unused_idata;
  assign legal = idata[6:0] == OP_LOAD && legal_f3(idata[14:12]);
  assign split_in = ((idata[14:12] == LH || idata[14:12] == LHU) && daddr[1:0] == 2'd3) ||
                    (idata[14:12] == LW && daddr[1:0] != 2'd0);
  assign base = {addr[MSB:2], 2'b00};
  assign unused_idata = ^{idata[MSB:15], idata[11:7]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (ld_valid) nxt = legal ? REQ0 : RESP;
      REQ0:    if (mem_gnt) nxt = WAIT0;
      WAIT0:   if (mem_rvalid) nxt = split ? REQ1 : RESP;
      REQ1:    if (mem_gnt) nxt = WAIT1;
      WAIT1:   if (mem_rvalid) nxt = RESP;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    ld_ready = state == IDLE;
    mem_req  = state == REQ0 || state == REQ1;
    mem_addr = state == REQ1 ? base + 32'd4 : base;
    rd_valid = state == RESP;
    rd_err   = rd_valid && err;
    rd_data  = rd_valid && !err ? aligned : '0;
  end
  // word1 is cleared on accept so non-split extraction sees zeros above word0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3    <= '0;
      addr  <= '0;
      w0    <= '0;
      w1    <= '0;
      split <= 1'b0;
      err   <= 1'b0;
    end else if (state == IDLE && ld_valid) begin
      f3    <= idata[14:12];
      addr  <= daddr;
      split <= split_in;
      err   <= !legal;
      w1    <= '0;
    end else if (state == WAIT0 && mem_rvalid) begin
      w0 <= mem_rdata;
    end else if (state == WAIT1 && mem_rvalid) begin
      w1 <= mem_rdata;
    end
  end
  load_align u_align (
    .word0  (w0),
    .word1  (w1),
    .offset (addr[1:0]),
    .funct3 (f3),
    .data   (aligned)
  );
endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: directed loads against a scripted memory, results checked via a scoreboard queue
module tb_load_unit;
  logic clk = 0, rst = 0, ld_valid = 0, mem_gnt = 0, mem_rvalid = 0;
  logic [31:0] idata = 0, daddr = 0, mem_rdata = 0;
  logic ld_ready, mem_req, rd_valid, rd_err;
  logic [31:0] mem_addr, rd_data;
  typedef struct {logic [31:0] d; logic e; int t;} exp_t;
  exp_t sb[$];
  int nvec = 0, nerr = 0, cyc = 0;

  load_unit dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .idata(idata), .daddr(daddr), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // d = grant delay per request, spur = rvalid noise while waiting for grant
  task automatic run_load(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] wa,
                          input logic [31:0] wb, input int nreq, input int d, input bit spur,
                          input logic [31:0] ed, input logic ee);
    exp_t e;
    logic [31:0] base;
    @(negedge clk);
    chk("ld_ready", ld_ready, 1);
    ld_valid = 1; idata = ins; daddr = a;
    e.d = ed; e.e = ee;
    e.t = cyc + (ee ? 1 : (nreq == 2 ? 5 : 3) + d * nreq);
    sb.push_back(e);
    @(negedge clk);
    ld_valid = 0;
    if (ee) chk("no_mem_req", mem_req, 0);
    else for (int n = 0; n < nreq; n++) begin
      base = {a[31:2], 2'b00} + 32'(4 * n);
      for (int i = 0; i < d; i++) begin
        chk("req_held", mem_req, 1);
        chk("addr_held", mem_addr, base);
        mem_rvalid = spur; mem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
      end
      chk("mem_req", mem_req, 1);
      chk("mem_addr", mem_addr, base);
      mem_rvalid = 0; mem_gnt = 1;
      @(negedge clk);
      mem_gnt = 0;
      chk("wait_no_req", mem_req, 0);
      mem_rvalid = 1; mem_rdata = n != 0 ? wb : wa;
      @(negedge clk);
      mem_rvalid = 0;
    end
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rd_valid === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_rd_valid_queue", sb.size(), 1);
      else begin
        e = sb.pop_front();
        chk("rd_data", rd_data, e.d);
        chk("rd_err", rd_err, e.e);
        chk("rd_cycle", cyc, e.t);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    #2 rst = 1;
    #1;
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_err", rd_err, 0);
    @(negedge clk) rst = 0;
    run_load(32'h0003, 32'h103, 32'h80FF1234, 0, 1, 0, 0, 32'hFFFFFF80, 0);
    run_load(32'h4003, 32'h103, 32'h80FF1234, 0, 1, 0, 0, 32'h00000080, 0);
    run_load(32'h5003, 32'h102, 32'h80FF1234, 0, 1, 0, 0, 32'h000080FF, 0);
    run_load(32'h1003, 32'h102, 32'h80FF1234, 0, 1, 0, 0, 32'hFFFF80FF, 0);
    run_load(32'h1003, 32'h101, 32'h80FF1234, 0, 1, 0, 0, 32'hFFFFFF12, 0);
    run_load(32'h4003, 32'h100, 32'h80FF1234, 0, 1, 0, 0, 32'h00000034, 0);
    run_load(32'h2003, 32'h101, 32'h44332211, 32'h88776655, 2, 0, 0, 32'h55443322, 0);
    run_load(32'h1003, 32'h103, 32'h80FF1234, 32'h88776655, 2, 3, 1, 32'h00005580, 0);
    run_load(32'h3003, 32'h100, 0, 0, 1, 0, 0, 32'h0, 1);
    run_load(32'h2023, 32'h100, 0, 0, 1, 0, 0, 32'h0, 1);
    run_load(32'h2003, 32'hFFFFFFFE, 32'hAABBCCDD, 32'h11223344, 2, 0, 0, 32'h3344AABB, 0);
    @(negedge clk);
    ld_valid = 1; idata = 32'h2003; daddr = 32'h200;
    @(negedge clk);
    ld_valid = 0;
    chk("mid_req", mem_req, 1);
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    chk("mid_wait_no_req", mem_req, 0);
    #2 rst = 1;
    #1;
    chk("mid_rst_ld_ready", ld_ready, 1);
    chk("mid_rst_mem_req", mem_req, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_rd_data", rd_data, 0);
    chk("mid_rst_rd_err", rd_err, 0);
    @(negedge clk);
    rst = 0; mem_rvalid = 1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_rvalid = 0;
    chk("late_rvalid_no_rd", rd_valid, 0);
    chk("late_rvalid_idle", ld_ready, 1);
    run_load(32'h2003, 32'h200, 32'hCAFEF00D, 0, 1, 0, 0, 32'hCAFEF00D, 0);
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
